multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 instr  in  32  instruction word from instruction memory, valid during FETCH.
REQ-005 zero  in  1  ALU zero flag from the datapath, sampled in EXEC.
REQ-006 ra, rb, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11] from the latched IR.
REQ-007 imm  out  16  IR[15:0] from the latched IR.
REQ-008 RegDst, RegWr, ExtOp, ALUSrc, MemWr, MemtoReg  out  1 each  datapath controls; RegDst=1 selects rd, ExtOp=1 selects sign-extend.
REQ-009 ALUctr  out  4  ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
REQ-010 IRWr, PCWr  out  1 each  IR load enable (internal, exported for observation); PC write enable.
REQ-011 PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
REQ-012 state  out  3  current FSM state; illegal  out  1  one-cycle flag for an unsupported opcode or funct.

Function
REQ-013 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; other codes SHALL go to FETCH.
REQ-014 FETCH: IRWr=1, IR loads instr at the clock edge; always goes to DECODE.
REQ-015 DECODE: classify the latched opcode (IR[31:26]) and funct (IR[5:0]); supported ops go to EXEC; unsupported ops assert illegal and go to FETCH with PCWr=1, PCSrc=00.
REQ-016 Supported ops: R-type (op 0x00; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, ori 0x0D, j 0x02.
REQ-017 EXEC drives ALUctr per op: R-type from funct, lw/sw/addi add with ALUSrc=1 and ExtOp=1, ori or with ALUSrc=1 and ExtOp=0, beq sub with ALUSrc=0.
REQ-018 EXEC transitions: lw/sw go to MEM; R-type/addi/ori go to WB; beq/j go to FETCH.
REQ-019 beq in EXEC: PCWr=zero, PCSrc=01. j in EXEC: PCWr=1, PCSrc=10.
REQ-020 MEM: sw asserts MemWr=1 and PCWr=1 (PCSrc=00), then goes to FETCH; lw goes to WB.
REQ-021 WB: RegWr=1 and PCWr=1 (PCSrc=00), then FETCH. RegDst=1 only for R-type. MemtoReg=1 only for lw.
REQ-022 Per-instruction latency SHALL be: beq/j 3 cycles; R-type/addi/ori/sw 4 cycles; lw 5 cycles; illegal 2 cycles.
REQ-023 Outputs SHALL be Moore functions of state plus latched IR, except PCWr in EXEC for beq, which also depends on zero.
REQ-024 ALUctr/ALUSrc/ExtOp SHALL hold their EXEC values through MEM and WB of the same instruction.
REQ-025 Outside the states named above, RegWr, MemWr, PCWr and illegal SHALL be 0.
REQ-026 instr changes outside FETCH SHALL have no effect.

Reset
REQ-027 reset SHALL force state=FETCH and IR=0 at the next edge; this takes priority over every transition, including mid-instruction (for example an abandoned MEM).
REQ-028 While reset is high, RegWr, MemWr, PCWr, IRWr and illegal SHALL be 0; ALUctr=0000; PCSrc=00.
REQ-029 The first FETCH SHALL occur in the first cycle after reset deasserts.

Structure
REQ-030 A shared package SHALL hold the state encodings, opcode/funct constants, ALUctr codes and PCSrc codes.
REQ-031 One sub-module, alu_decode, SHALL map {opcode, funct} to ALUctr and the illegal indication.

Verification
REQ-032 addi: instr=0x20220012 after reset -> states F,D,E,WB; ra=1, rb=2, imm=0x0012; ALUctr=0010, ALUSrc=1, ExtOp=1, RegWr=1 in WB, RegDst=0.
REQ-033 lw 0x8C430004 -> 5 cycles; MemtoReg=1 and RegWr=1 only in WB; MemWr=0 throughout.
REQ-034 sw 0xAC430004 -> MemWr=1 in MEM only; RegWr never asserted; 4 cycles.
REQ-035 beq 0x10220003 with zero=1 -> PCWr=1, PCSrc=01 in EXEC; with zero=0 -> PCWr=0; 3 cycles in both cases.
REQ-036 Illegal opcode 0x3F -> illegal=1 in DECODE, back to FETCH, no RegWr or MemWr.
REQ-037 reset pulsed during MEM of lw -> next state FETCH, no WB, no RegWr.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// opcode/funct values, ALU operation codes and PC source selects.
package multicycle_ctrl_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned ALUCTR_W = 4;
  localparam int unsigned PCSRC_W  = 2;

  localparam logic [STATE_W-1:0] S_FETCH  = 3'd0;
  localparam logic [STATE_W-1:0] S_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] S_EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] S_MEM    = 3'd3;
  localparam logic [STATE_W-1:0] S_WB     = 3'd4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALUCTR_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUCTR_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUCTR_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUCTR_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUCTR_W-1:0] ALU_SLT = 4'b0111;

  localparam logic [PCSRC_W-1:0] PC_SEQ = 2'b00;
  localparam logic [PCSRC_W-1:0] PC_BR  = 2'b01;
  localparam logic [PCSRC_W-1:0] PC_JMP = 2'b10;

  // Field view of a latched instruction word.
  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   shamt;
    logic [FUNCT_W-1:0] funct;
  } instr_t;

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// Maps {opcode, funct} to the ALU operation and flags anything outside the
// supported instruction subset as illegal.
module alu_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]     opcode,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUCTR_W-1:0] aluctr_c,
  output logic                illegal_c
);

  always_comb begin
    aluctr_c  = ALU_AND;
    illegal_c = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD:  aluctr_c = ALU_ADD;
          FN_SUB:  aluctr_c = ALU_SUB;
          FN_AND:  aluctr_c = ALU_AND;
          FN_OR:   aluctr_c = ALU_OR;
          FN_SLT:  aluctr_c = ALU_SLT;
          default: illegal_c = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: aluctr_c = ALU_ADD;
      OP_ORI:                aluctr_c = ALU_OR;
      OP_BEQ:                aluctr_c = ALU_SUB;
      OP_J:                  aluctr_c = ALU_AND;
      default:               illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Five-state multicycle controller: latches the instruction in FETCH and
// sequences datapath controls through DECODE/EXEC/MEM/WB.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                zero,
  output logic [REG_W-1:0]    ra,
  output logic [REG_W-1:0]    rb,
  output logic [REG_W-1:0]    rd,
  output logic [IMM_W-1:0]    imm,
  output logic                RegDst,
  output logic                RegWr,
  output logic                ExtOp,
  output logic                ALUSrc,
  output logic                MemWr,
  output logic                MemtoReg,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic                IRWr,
  output logic                PCWr,
  output logic [PCSRC_W-1:0]  PCSrc,
  output logic [STATE_W-1:0]  state,
  output logic                illegal
);

  instr_t               ir;
  logic [STATE_W-1:0]   state_d;
  logic [ALUCTR_W-1:0]  dec_aluctr;
  logic                 dec_illegal;
  logic                 is_rtype, is_lw, is_sw, is_beq, is_j, is_addi, is_ori;
  logic                 alu_phase;

  alu_decode u_alu_decode (
    .opcode    (ir.op),
    .funct     (ir.funct),
    .aluctr_c  (dec_aluctr),
    .illegal_c (dec_illegal)
  );

  assign is_rtype = (ir.op == OP_RTYPE);
  assign is_lw    = (ir.op == OP_LW);
  assign is_sw    = (ir.op == OP_SW);
  assign is_beq   = (ir.op == OP_BEQ);
  assign is_j     = (ir.op == OP_J);
  assign is_addi  = (ir.op == OP_ADDI);
  assign is_ori   = (ir.op == OP_ORI);

  assign ra  = ir.rs;
  assign rb  = ir.rt;
  assign rd  = ir.rd;
  assign imm = {ir.rd, ir.shamt, ir.funct};

  // State and instruction register; reset wins over any pending transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= state_d;
      if (IRWr) ir <= instr_t'(instr);
    end
  end

  // ALU controls stay stable from EXEC through the end of the instruction.
  assign alu_phase = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

  always_comb begin
    state_d  = S_FETCH;
    RegDst   = 1'b0;
    RegWr    = 1'b0;
    ExtOp    = 1'b0;
    ALUSrc   = 1'b0;
    MemWr    = 1'b0;
    MemtoReg = 1'b0;
    ALUctr   = ALU_AND;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    PCSrc    = PC_SEQ;
    illegal  = 1'b0;

    if (alu_phase) begin
      ALUctr = dec_aluctr;
      ALUSrc = is_lw | is_sw | is_addi | is_ori;
      ExtOp  = is_lw | is_sw | is_addi | is_beq;
    end

    case (state)
      S_FETCH: begin
        IRWr    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_illegal) begin
          illegal = 1'b1;
          PCWr    = 1'b1;
          PCSrc   = PC_SEQ;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_beq) begin
          PCWr    = zero;
          PCSrc   = PC_BR;
          state_d = S_FETCH;
        end else if (is_j) begin
          PCWr    = 1'b1;
          PCSrc   = PC_JMP;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          state_d = S_WB;
        end else begin
          MemWr   = is_sw;
          PCWr    = 1'b1;
          PCSrc   = PC_SEQ;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        RegWr    = 1'b1;
        PCWr     = 1'b1;
        PCSrc    = PC_SEQ;
        RegDst   = is_rtype;
        MemtoReg = is_lw;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Hold every datapath control inactive while reset is asserted.
    if (reset) begin
      RegDst   = 1'b0;
      RegWr    = 1'b0;
      ExtOp    = 1'b0;
      ALUSrc   = 1'b0;
      MemWr    = 1'b0;
      MemtoReg = 1'b0;
      ALUctr   = ALU_AND;
      IRWr     = 1'b0;
      PCWr     = 1'b0;
      PCSrc    = PC_SEQ;
      illegal  = 1'b0;
    end
  end

endmodule
